cmd_uart_comm: RTL and testbench
================================

# cmd_uart_comm

Host-side serial endpoint for the scope's digital core. It deserializes 8N1 UART bytes from the host into 24-bit commands, and presents them on a `cmd`/`cmd_rdy`/`clr_cmd_rdy` handshake. It serializes single response bytes requested on `send_resp` and reports completion on `resp_sent`. It sits between the board RX/TX pins and the core's command interpreter.

## Interface
- `BAUD_DIV`, 434: clocks per bit (50 MHz / 115200); minimum 16.
- `BYTE_TIMEOUT`, 65535: idle clocks allowed between bytes of a partial command.
- `clk` in 1: system clock, all logic rising-edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `RX` in 1: serial input from host, asynchronous, idle high.
- `TX` out 1: serial output to host, idle high.
- `cmd` out 24: last complete command; first byte received lands in `[23:16]`.
- `cmd_rdy` out 1: `cmd` valid, held until cleared.
- `clr_cmd_rdy` in 1: single-cycle pulse from the core; clears `cmd_rdy`.
- `resp_data` in 8: response byte, sampled when `send_resp` is accepted.
- `send_resp` in 1: request to transmit `resp_data`.
- `resp_sent` out 1: one-cycle pulse at end of the stop bit.
- `tx_busy` out 1: transmitter occupied.

## Operation
- Reset values: `TX`=1, `cmd`=0, `cmd_rdy`=0, `resp_sent`=0, `tx_busy`=0. The RX synchronizer flops reset to 1, and the byte counter resets to 0.
- **RX path:** `RX` passes through a 2-flop synchronizer. Receiver FSM states are IDLE, START, DATA and STOP.
  - IDLE → START on a synced falling edge.
  - In START, RX is resampled at `BAUD_DIV/2`. If it is high, the start is false and the FSM returns to IDLE.
  - DATA samples 8 bits at mid-bit, LSB first.
  - In STOP, a mid-bit sample of 1 means the byte is accepted. A sample of 0 is a framing error: the byte is discarded, the byte counter is reset to 0, and the FSM returns to IDLE without waiting for line high.
- **Command assembly:** accepted bytes shift into a 24-bit holding register, with the byte counter running 0→1→2.
  - On the 3rd byte, `cmd` loads the holding register, `cmd_rdy` sets, and the counter wraps to 0.
  - A new command completing while `cmd_rdy`=1 overwrites `cmd`, and `cmd_rdy` stays 1.
  - If set and clear happen in the same cycle, set wins.
  - Partial bytes never disturb `cmd`.
- **Timeout:** the inter-byte counter counts while the counter is nonzero and the receiver is IDLE. When it reaches `BYTE_TIMEOUT`, the byte counter returns to 0 and the partial command is dropped.
- **TX path:** transmitter FSM states are IDLE, START, DATA and STOP.
  - `send_resp` in IDLE latches `resp_data` and sets `tx_busy`.
  - The frame is start(0), 8 data bits LSB first, stop(1), each held `BAUD_DIV` clocks.
  - `send_resp` while `tx_busy`=1 is ignored; it is neither queued nor corrupting.
  - When the stop bit completes, the FSM clears `tx_busy` and pulses `resp_sent`, then returns to IDLE.
- RX and TX are fully independent. Full-duplex traffic is legal.
- **Reset mid-frame:** every FSM and counter aborts immediately. `TX` goes high, and any partial command is lost.

## Timing
- **TX start latency:** `TX` drops to 0 in the cycle after `send_resp` is sampled. `tx_busy` rises in that same cycle.
- **TX frame length:** exactly 10·`BAUD_DIV` clocks from the `TX` falling edge to `resp_sent`. `resp_sent` is high in the cycle in which `tx_busy` falls.
- **Back-to-back TX:** `send_resp` in the same cycle as `resp_sent` is ignored (still busy). The next cycle is accepted.
- **RX latency:** `cmd_rdy` rises 2 (synchronizer) + 1 clocks after the stop-bit mid-sample point of the 3rd byte. `cmd` is valid in the same cycle.
- **Clearing:** `cmd_rdy` falls in the cycle after `clr_cmd_rdy`.
- **Baud tolerance:** ±4% rate mismatch must be received correctly.

## Structure
- Shared package `uart_pkg`: `rx_state_t` and `tx_state_t` enums, `CMD_BYTES`=3, and the frame-bit constants.
- Natural sub-module: `uart_rx`, containing the synchronizer, receiver FSM, baud and bit counters. Its outputs are `rx_data[7:0]`, a `rx_rdy` pulse and a `frm_err` pulse.
- The command assembly, timeout logic and transmitter live in the top.

## Test plan
- **Single command:** host sends 0x02, 0x0A, 0x55 at `BAUD_DIV`=16 → `cmd`=0x020A55, `cmd_rdy`=1 until `clr_cmd_rdy`, then 0 the cycle after.
- **Response:** `send_resp` with `resp_data`=0xA5 → TX bits 0,1,0,1,0,0,1,0,1,1, each 16 clocks. `resp_sent` pulses at clock 160. A second `send_resp` at clock 80 produces no extra frame.
- **Framing error:** the 2nd byte is sent with stop=0, then 3 good bytes 0x11, 0x22, 0x33 → `cmd`=0x112233, with no earlier `cmd_rdy`.
- **Timeout:** send 0xFF, idle for `BYTE_TIMEOUT`+1 clocks, then send 0x01, 0x02, 0x03 → `cmd`=0x010203.
- **Contention:** a 3rd byte completes in the same cycle as `clr_cmd_rdy` → `cmd_rdy` stays 1 with the new `cmd`. A glitch of 4 clocks low on `RX` causes no byte.
- **Reset mid-TX:** assert `rst` at clock 50 of a frame → `TX`=1, `tx_busy`=0 and no `resp_sent`. A new `send_resp` after release transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the host UART endpoint.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int unsigned CMD_BYTES = 3;
    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam logic        LINE_IDLE = 1'b1;

endpackage

// File: rtl/cmd_uart_comm_if.sv
// Command / response handshake between the UART endpoint and the core.
interface cmd_uart_comm_if;

    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;

    // core side
    modport master (
        input  cmd, cmd_rdy, resp_sent, tx_busy,
        output clr_cmd_rdy, resp_data, send_resp
    );

    // UART endpoint side
    modport slave (
        output cmd, cmd_rdy, resp_sent, tx_busy,
        input  clr_cmd_rdy, resp_data, send_resp
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: input synchronizer, mid-bit sampling FSM, byte/framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       rx_idle
);

    localparam int unsigned    CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]  FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]  HALF = CW'(BAUD_DIV / 2 - 1);

    logic [1:0]    sync;
    logic          rx_prev;
    logic          rx_s;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;

    assign rx_s    = sync[1];
    assign rx_data = shreg;
    assign rx_idle = (state == RX_IDLE);

    // two-flop synchronizer plus previous-value flop for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], rx};
            rx_prev <= rx_s;
        end
    end

    // receiver state register and baud/bit/shift datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end

    // next-state logic; sampling happens when the baud counter hits its target
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        bit_n   = bit_idx;
        shreg_n = shreg;
        rx_rdy  = 1'b0;
        frm_err = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_s) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'(DATA_BITS - 1)) state_n = RX_STOP;
                    else                              bit_n   = bit_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (rx_s == STOP_BIT) rx_rdy  = 1'b1;
                    else                  frm_err = 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/cmd_uart_comm.sv
// Host serial endpoint: assembles 3-byte commands from RX, sends single response bytes on TX.
module cmd_uart_comm
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV     = 434,
    parameter int unsigned BYTE_TIMEOUT = 65535
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           RX,
    output logic           TX,
    cmd_uart_comm_if.slave host
);

    localparam int unsigned   CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam int unsigned   TW   = $clog2(BYTE_TIMEOUT + 1);

    logic [7:0]    rx_data;
    logic          rx_rdy, frm_err, rx_idle;
    logic [1:0]    byte_cnt;
    logic [15:0]   hold;
    logic [TW-1:0] to_cnt;

    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shreg, tx_shreg_n;
    logic          tx_n, busy_n, sent_n;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (RX),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .frm_err (frm_err),
        .rx_idle (rx_idle)
    );

    // command assembly and inter-byte timeout; only the first two bytes need holding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt     <= '0;
            hold         <= '0;
            to_cnt       <= '0;
            host.cmd     <= '0;
            host.cmd_rdy <= 1'b0;
        end else begin
            if (host.clr_cmd_rdy) host.cmd_rdy <= 1'b0;
            if (frm_err) begin
                byte_cnt <= '0;
                to_cnt   <= '0;
            end else if (rx_rdy) begin
                to_cnt <= '0;
                if (byte_cnt == 2'(CMD_BYTES - 1)) begin
                    host.cmd     <= {hold, rx_data};
                    host.cmd_rdy <= 1'b1;
                    byte_cnt     <= '0;
                end else begin
                    hold     <= {hold[7:0], rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (byte_cnt != '0 && rx_idle) begin
                if (to_cnt == TW'(BYTE_TIMEOUT)) begin
                    byte_cnt <= '0;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // transmitter state register and registered line/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state       <= TX_IDLE;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_shreg       <= '0;
            TX             <= LINE_IDLE;
            host.tx_busy   <= 1'b0;
            host.resp_sent <= 1'b0;
        end else begin
            tx_state       <= tx_state_n;
            tx_cnt         <= tx_cnt_n;
            tx_bit         <= tx_bit_n;
            tx_shreg       <= tx_shreg_n;
            TX             <= tx_n;
            host.tx_busy   <= busy_n;
            host.resp_sent <= sent_n;
        end
    end

    // transmitter next-state and next-output logic
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_bit_n   = tx_bit;
        tx_shreg_n = tx_shreg;
        tx_n       = TX;
        busy_n     = host.tx_busy;
        sent_n     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                tx_n     = LINE_IDLE;
                busy_n   = 1'b0;
                // a request seen during the resp_sent cycle is still treated as busy
                if (host.send_resp && !host.resp_sent) begin
                    tx_state_n = TX_START;
                    tx_shreg_n = host.resp_data;
                    tx_n       = START_BIT;
                    busy_n     = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt == FULL) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                    tx_n       = tx_shreg[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == FULL) begin
                    tx_cnt_n   = '0;
                    tx_shreg_n = tx_shreg >> 1;
                    if (tx_bit == 3'(DATA_BITS - 1)) begin
                        tx_state_n = TX_STOP;
                        tx_n       = STOP_BIT;
                    end else begin
                        tx_bit_n = tx_bit + 3'd1;
                        tx_n     = tx_shreg[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == FULL) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                    busy_n     = 1'b0;
                    sent_n     = 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cmd_uart_comm.sv
// Self-checking bench for cmd_uart_comm: directed scenarios plus randomized traffic
// checked against a byte-queue command model and an ideal 8N1 frame model.
module tb_cmd_uart_comm;

    localparam int unsigned BD   = 16;
    localparam int unsigned BT   = 300;
    localparam int unsigned CLK  = 100;
    localparam int unsigned NOM  = BD * CLK;
    localparam int unsigned FAST = NOM - NOM / 25;
    localparam int unsigned SLOW = NOM + NOM / 25;

    logic clk = 1'b0;
    logic rst;
    logic RX;
    logic TX;

    cmd_uart_comm_if host();

    cmd_uart_comm #(.BAUD_DIV(BD), .BYTE_TIMEOUT(BT)) dut (
        .clk  (clk),
        .rst  (rst),
        .RX   (RX),
        .TX   (TX),
        .host (host)
    );

    always #(CLK / 2) clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pend[$];
    logic [23:0] exp_cmd;
    logic        exp_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // command model: good bytes accumulate, errors/timeouts drop, three make a command
    function automatic void model_byte(input logic [7:0] b, input logic good);
        if (!good) begin
            pend.delete();
        end else begin
            pend.push_back(b);
            if (pend.size() == 3) begin
                exp_cmd = {pend[0], pend[1], pend[2]};
                exp_rdy = 1'b1;
                pend.delete();
            end
        end
    endfunction

    function automatic void model_gap(input int unsigned idle_clks);
        if (idle_clks > BT) pend.delete();
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int unsigned c);
        int unsigned idx;
        idx = c / BD;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx - 1];
        return 1'b1;
    endfunction

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drive one 8N1 frame; bit_t in time units, starts immediately
    task automatic send_byte(input logic [7:0] b, input logic stop, input int unsigned bit_t);
        RX = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            #(bit_t);
        end
        RX = stop;
        #(bit_t);
        RX = 1'b1;
    endtask

    task automatic check_cmd(input string tag);
        chk({tag, "_rdy"}, 32'(host.cmd_rdy), 32'(exp_rdy));
        chk({tag, "_cmd"}, 32'(host.cmd), 32'(exp_cmd));
    endtask

    task automatic host_byte(input logic [7:0] b, input logic stop, input int unsigned bit_t,
                             input int unsigned gap, input string tag);
        send_byte(b, stop, bit_t);
        idle(gap);
        model_byte(b, stop);
        model_gap(gap);
        check_cmd(tag);
    endtask

    task automatic clr_pulse(input string tag);
        host.clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        host.clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        chk({tag, "_clr"}, 32'(host.cmd_rdy), 32'(exp_rdy));
    endtask

    // one response frame, checked every clock; poke adds an ignored request mid-frame
    task automatic tx_send(input logic [7:0] b, input logic poke, input string tag);
        host.resp_data = b;
        host.send_resp = 1'b1;
        @(posedge clk);
        #1;
        host.send_resp = 1'b0;
        host.resp_data = 8'($urandom);
        for (int unsigned c = 0; c <= 10 * BD; c++) begin
            chk({tag, "_tx"}, 32'(TX), 32'((c < 10 * BD) ? frame_bit(b, c) : 1'b1));
            chk({tag, "_busy"}, 32'(host.tx_busy), 32'(c < 10 * BD));
            chk({tag, "_sent"}, 32'(host.resp_sent), 32'(c == 10 * BD));
            if (poke && c == 79) begin
                host.send_resp = 1'b1;
                host.resp_data = 8'h3C;
            end
            if (c == 80) host.send_resp = 1'b0;
            if (c < 10 * BD) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int unsigned sent_cnt;
        int unsigned low_cnt;
        logic [7:0]  rb;
        int unsigned bt;

        rst = 1'b1;
        RX  = 1'b1;
        host.clr_cmd_rdy = 1'b0;
        host.send_resp   = 1'b0;
        host.resp_data   = '0;
        exp_cmd = '0;
        exp_rdy = 1'b0;
        idle(3);
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_busy", 32'(host.tx_busy), 32'd0);
        chk("rst_sent", 32'(host.resp_sent), 32'd0);
        check_cmd("rst");
        rst = 1'b0;
        idle(5);

        // single command with exact latency probe on the third byte
        host_byte(8'h02, 1'b1, NOM, 20, "single_b1");
        host_byte(8'h0A, 1'b1, NOM, 20, "single_b2");
        fork
            send_byte(8'h55, 1'b1, NOM);
            begin
                repeat (154) @(posedge clk);
                #1;
                chk("rx_latency_before", 32'(host.cmd_rdy), 32'd0);
                @(posedge clk);
                #1;
                chk("rx_latency_at", 32'(host.cmd_rdy), 32'd1);
                chk("rx_latency_cmd", 32'(host.cmd), 32'h020A55);
            end
        join
        idle(20);
        model_byte(8'h55, 1'b1);
        check_cmd("single_b3");
        idle(30);
        check_cmd("single_hold");
        clr_pulse("single");

        // response frame, ignored mid-frame request, ignored request in resp_sent cycle
        tx_send(8'hA5, 1'b1, "resp_a5");
        host.resp_data = 8'h5A;
        host.send_resp = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_ignored_tx", 32'(TX), 32'd1);
        chk("b2b_ignored_busy", 32'(host.tx_busy), 32'd0);
        tx_send(8'h5A, 1'b0, "b2b_next");
        idle(10);

        // reset in the middle of a frame, with a partial command pending
        host_byte(8'h99, 1'b1, NOM, 10, "partial");
        host.resp_data = 8'hC3;
        host.send_resp = 1'b1;
        @(posedge clk);
        #1;
        host.send_resp = 1'b0;
        idle(50);
        rst = 1'b1;
        #1;
        pend.delete();
        exp_cmd = '0;
        exp_rdy = 1'b0;
        chk("midrst_tx", 32'(TX), 32'd1);
        chk("midrst_busy", 32'(host.tx_busy), 32'd0);
        check_cmd("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sent_cnt = 0;
        low_cnt  = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (host.resp_sent) sent_cnt++;
            if (!TX) low_cnt++;
        end
        chk("midrst_no_sent", sent_cnt, 0);
        chk("midrst_tx_idle", low_cnt, 0);
        tx_send(8'h96, 1'b0, "after_rst");
        idle(10);
        host_byte(8'h12, 1'b1, NOM, 20, "post_rst_b1");
        host_byte(8'h34, 1'b1, NOM, 20, "post_rst_b2");
        host_byte(8'h56, 1'b1, NOM, 20, "post_rst_b3");
        clr_pulse("post_rst");

        // framing error discards the partial command
        host_byte(8'h77, 1'b1, NOM, 20, "frm_b1");
        host_byte(8'h88, 1'b0, NOM, 20, "frm_bad");
        host_byte(8'h11, 1'b1, NOM, 20, "frm_g1");
        host_byte(8'h22, 1'b1, NOM, 20, "frm_g2");
        host_byte(8'h33, 1'b1, NOM, 20, "frm_g3");
        clr_pulse("frm");

        // inter-byte timeout
        host_byte(8'hFF, 1'b1, NOM, BT + 1, "to_b0");
        host_byte(8'h01, 1'b1, NOM, 20, "to_b1");
        host_byte(8'h02, 1'b1, NOM, 20, "to_b2");
        host_byte(8'h03, 1'b1, NOM, 20, "to_b3");

        // set and clear in the same cycle: set wins
        host_byte(8'h44, 1'b1, NOM, 20, "cont_b1");
        host_byte(8'h55, 1'b1, NOM, 20, "cont_b2");
        fork
            send_byte(8'h66, 1'b1, NOM);
            begin
                repeat (154) @(posedge clk);
                #1;
                host.clr_cmd_rdy = 1'b1;
                @(posedge clk);
                #1;
                host.clr_cmd_rdy = 1'b0;
                chk("cont_rdy", 32'(host.cmd_rdy), 32'd1);
                chk("cont_cmd", 32'(host.cmd), 32'h445566);
                @(posedge clk);
                #1;
                chk("cont_rdy_held", 32'(host.cmd_rdy), 32'd1);
            end
        join
        idle(20);
        model_byte(8'h66, 1'b1);
        check_cmd("cont_after");
        clr_pulse("cont");

        // short low glitch must not start a byte
        RX = 1'b0;
        idle(4);
        RX = 1'b1;
        idle(40);
        host_byte(8'hAB, 1'b1, NOM, 20, "glitch_b1");
        host_byte(8'hCD, 1'b1, NOM, 20, "glitch_b2");
        host_byte(8'hEF, 1'b1, NOM, 20, "glitch_b3");

        // randomized traffic at nominal and +/-4% bit rates
        for (int k = 0; k < 18; k++) begin
            rb = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       bt = FAST;
                1:       bt = SLOW;
                default: bt = NOM;
            endcase
            host_byte(rb, ($urandom_range(0, 9) != 0), bt, $urandom_range(6, 60), "rand");
            if ($urandom_range(0, 3) == 0) clr_pulse("rand");
        end

        // full duplex: response frame while a command arrives
        fork
            tx_send(8'($urandom), 1'b0, "duplex_tx");
            begin
                host_byte(8'hDE, 1'b1, NOM, 8, "duplex_b1");
                host_byte(8'hAD, 1'b1, NOM, 8, "duplex_b2");
                host_byte(8'hBE, 1'b1, NOM, 8, "duplex_b3");
            end
        join
        idle(20);
        check_cmd("duplex_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
